// File: rtl/lane_override_arbiter.sv
// Round-robin arbiter for ownership of the 8-lane force/release override.
// Grants one owner at a time, bounds hold time, and inserts a release cycle between owners.
`timescale 1ns/1ps
module lane_override_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [2*N_REQ-1:0] i_grp,
    input  logic [N_REQ-1:0]   i_mode_z,
    input  logic [N_REQ-1:0]   i_val,
    output logic [N_REQ-1:0]   o_gnt,
    output logic               o_en_lo,
    output logic               o_en_hi,
    output logic               o_mode_z,
    output logic               o_val,
    output logic               o_timeout
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    // Handshake: i_req is a level request; ownership is held while o_gnt[k] is high,
    // and the owner releases by dropping i_req[k]. A grant is never re-issued without
    // an intervening cycle in which o_gnt and both enables are zero.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [IW-1:0]    owner_q, owner_n;
    logic [IW-1:0]    ptr_q, ptr_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [N_REQ-1:0] gnt_n;
    logic             en_lo_n, en_hi_n, mode_z_n, val_n, timeout_n;

    logic [N_REQ-1:0] eligible;
    logic             found;
    logic [IW-1:0]    sel;
    logic [1:0]       grp_sel;

    always_comb begin
        eligible = '0;
        for (int k = 0; k < N_REQ; k++) begin
            eligible[k] = i_req[k] & (|i_grp[2*k +: 2]);
        end
    end

    // Search upward from the slot after the last owner, so that owner ranks lowest.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        found = 1'b0;
        sel   = ptr_q;
        idx   = 0;
        cand  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = IW'(idx);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign grp_sel = i_grp[{sel, 1'b0} +: 2];

    always_comb begin
        state_n   = state_q;
        owner_n   = owner_q;
        ptr_n     = ptr_q;
        cnt_n     = cnt_q;
        gnt_n     = '0;
        en_lo_n   = 1'b0;
        en_hi_n   = 1'b0;
        mode_z_n  = 1'b0;
        val_n     = 1'b0;
        timeout_n = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_n    = OWN;
                    owner_n    = sel;
                    cnt_n      = '0;
                    gnt_n[sel] = 1'b1;
                    en_lo_n    = grp_sel[0];
                    en_hi_n    = grp_sel[1];
                    mode_z_n   = i_mode_z[sel];
                    val_n      = i_val[sel];
                end
            end
            OWN: begin
                cnt_n = cnt_q + CW'(1);
                if (!i_req[owner_q]) begin
                    state_n = DRAIN;
                end else if (cnt_q == CW'(MAX_HOLD - 1)) begin
                    state_n   = DRAIN;
                    timeout_n = 1'b1;
                end else begin
                    // Output registers double as the latch of the owner's settings.
                    gnt_n    = o_gnt;
                    en_lo_n  = o_en_lo;
                    en_hi_n  = o_en_hi;
                    mode_z_n = o_mode_z;
                    val_n    = o_val;
                end
            end
            DRAIN: begin
                ptr_n   = owner_q;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= IW'(N_REQ - 1);
            cnt_q     <= '0;
            o_gnt     <= '0;
            o_en_lo   <= 1'b0;
            o_en_hi   <= 1'b0;
            o_mode_z  <= 1'b0;
            o_val     <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            state_q   <= state_n;
            owner_q   <= owner_n;
            ptr_q     <= ptr_n;
            cnt_q     <= cnt_n;
            o_gnt     <= gnt_n;
            o_en_lo   <= en_lo_n;
            o_en_hi   <= en_hi_n;
            o_mode_z  <= mode_z_n;
            o_val     <= val_n;
            o_timeout <= timeout_n;
        end
    end

endmodule

// File: tb/tb_lane_override_arbiter.sv
// Bench for lane_override_arbiter: directed scenarios plus random traffic,
// every cycle compared against an ownership-level reference model.
`timescale 1ns/1ps
module tb_lane_override_arbiter;

    localparam int N   = 4;
    localparam int MAX = 16;

    logic           clk    = 1'b0;
    logic           rst_n  = 1'b0;
    logic [N-1:0]   req    = '0;
    logic [2*N-1:0] grp    = '0;
    logic [N-1:0]   mode_z = '0;
    logic [N-1:0]   val    = '0;
    logic [N-1:0]   gnt;
    logic           en_lo, en_hi, mode_o, val_o, timeout;

    int checks = 0;
    int errors = 0;

    lane_override_arbiter #(.N_REQ(N), .MAX_HOLD(MAX)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_req    (req),
        .i_grp    (grp),
        .i_mode_z (mode_z),
        .i_val    (val),
        .o_gnt    (gnt),
        .o_en_lo  (en_lo),
        .o_en_hi  (en_hi),
        .o_mode_z (mode_o),
        .o_val    (val_o),
        .o_timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: tracks who owns the override, how many cycles they have
    // held it, whether a release cycle is pending, and who owned it last.
    int           m_owner, m_held, m_last, mk;
    bit           m_drain;
    logic [1:0]   mg;
    logic [N-1:0] e_gnt;
    logic         e_en_lo, e_en_hi, e_mode, e_val, e_to;

    function automatic logic bit_of(input logic [N-1:0] v, input int k);
        return 1'((v >> k) & 1'b1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_held = 0; m_last = N - 1; m_drain = 1'b0;
            e_gnt = '0; e_en_lo = 0; e_en_hi = 0; e_mode = 0; e_val = 0; e_to = 0;
        end else begin
            e_to = 1'b0;
            if (m_owner >= 0) begin
                if (!bit_of(req, m_owner) || m_held == MAX) begin
                    e_to    = bit_of(req, m_owner);
                    m_last  = m_owner;
                    m_owner = -1;
                    m_drain = 1'b1;
                    e_gnt = '0; e_en_lo = 0; e_en_hi = 0; e_mode = 0; e_val = 0;
                end else begin
                    m_held++;
                end
            end else if (m_drain) begin
                m_drain = 1'b0;
            end else begin
                for (int i = 1; i <= N; i++) begin
                    mk = (m_last + i) % N;
                    mg = 2'(grp >> (2 * mk));
                    if (m_owner < 0 && bit_of(req, mk) && mg != 2'b00) begin
                        m_owner = mk;
                        m_held  = 1;
                        e_gnt   = N'(1) << mk;
                        e_en_lo = mg[0];
                        e_en_hi = mg[1];
                        e_mode  = bit_of(mode_z, mk);
                        e_val   = bit_of(val, mk);
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("m_gnt", 32'(gnt), 32'(e_gnt));
        check("m_en_lo", 32'(en_lo), 32'(e_en_lo));
        check("m_en_hi", 32'(en_hi), 32'(e_en_hi));
        check("m_mode_z", 32'(mode_o), 32'(e_mode));
        check("m_val", 32'(val_o), 32'(e_val));
        check("m_timeout", 32'(timeout), 32'(e_to));
        check("en_gate", 32'((en_lo | en_hi) && gnt == '0), 32'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'(0));
        check({tag, "_en"}, 32'({en_hi, en_lo}), 32'(0));
        check({tag, "_mv"}, 32'({mode_o, val_o}), 32'(0));
        check({tag, "_to"}, 32'(timeout), 32'(0));
    endtask

    task automatic do_reset();
        req = '0; grp = '0; mode_z = '0; val = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst_n = 1'b1;
    endtask

    int waited, hi, guard, exp_k;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic grant on LO group in Z mode, then release through one drain cycle.
        do_reset();
        tick();
        req = 4'b0001; grp = 8'b0000_0001; mode_z = 4'b0001;
        tick();
        check("t1_gnt", 32'(gnt), 32'b0001);
        check("t1_en", 32'({en_hi, en_lo}), 32'b01);
        check("t1_mode", 32'(mode_o), 32'(1));
        req = '0;
        tick();
        check_all_zero("t1_drain");
        tick();
        check_all_zero("t1_idle");

        // Round robin across all four requesters.
        do_reset();
        req = '1; grp = '1;
        for (int n = 0; n < 5; n++) begin
            exp_k  = n % N;
            waited = 0;
            while (gnt == '0 && waited < 10) begin
                tick();
                waited++;
            end
            check("rr_gnt", 32'(gnt), 32'(N'(1) << exp_k));
            check("rr_wait", 32'(waited), (n == 0) ? 32'(1) : 32'(2));
            tick();
            tick();
            req[exp_k] = 1'b0;
            tick();
            check("rr_drain", 32'(gnt), 32'(0));
            req[exp_k] = 1'b1;
        end

        // Forced release after MAX cycles, then re-grant to the sole requester.
        do_reset();
        req = 4'b0100; grp = 8'b0011_0000;
        tick();
        check("to_first", 32'(gnt), 32'b0100);
        hi = 0; guard = 0;
        while (gnt == 4'b0100 && guard < 40) begin
            hi++;
            tick();
            guard++;
        end
        check("to_len", 32'(hi), 32'(MAX));
        check("to_pulse", 32'(timeout), 32'(1));
        check("to_en", 32'({en_hi, en_lo}), 32'(0));
        tick();
        check("to_clear", 32'(timeout), 32'(0));
        tick();
        check("to_regrant", 32'(gnt), 32'b0100);
        req = '0;
        tick();
        tick();

        // Latched value ignores later changes; empty group mask is never granted.
        do_reset();
        req = 4'b0011; grp = 8'b0000_0001;
        tick();
        check("lv_gnt", 32'(gnt), 32'b0001);
        check("lv_val0", 32'(val_o), 32'(0));
        val[0] = 1'b1;
        tick();
        tick();
        check("lv_hold", 32'(val_o), 32'(0));
        req[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("grp00_never", 32'(gnt), 32'(0));
        end
        req[0] = 1'b1;
        tick();
        check("lv_regrant", 32'(gnt), 32'b0001);
        check("lv_val1", 32'(val_o), 32'(1));
        req = '0;
        tick();
        tick();

        // Asynchronous reset while owned, then priority back to requester 0.
        do_reset();
        req = 4'b0001; grp = 8'b0000_0011; mode_z = 4'b0001; val = 4'b0001;
        tick();
        check("ar_gnt", 32'(gnt), 32'b0001);
        #3 rst_n = 1'b0;
        #1;
        check_all_zero("ar_async");
        req = 4'b1001; grp = 8'b0100_0001;
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("ar_prio", 32'(gnt), 32'b0001);
        req = '0;
        tick();
        tick();

        // Release coinciding with the last permitted hold cycle is not a timeout.
        do_reset();
        req = 4'b0001; grp = 8'b0000_0011;
        tick();
        check("edge_gnt", 32'(gnt), 32'b0001);
        repeat (15) tick();
        check("edge_held", 32'(gnt), 32'b0001);
        req = '0;
        tick();
        check("edge_drain", 32'(gnt), 32'(0));
        check("edge_no_to", 32'(timeout), 32'(0));
        tick();

        // Random traffic against the model, with occasional mid-cycle resets.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 11) == 0) req[k] = ~req[k];
                if ($urandom_range(0, 15) == 0) grp[2*k +: 2] = 2'($urandom_range(0, 3));
            end
            mode_z = N'($urandom);
            val    = N'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #1 check_model();
                #2 rst_n = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_override_arbiter.md
Name: lane_override_arbiter

Overview:
- Arbitrates ownership of the force/release override of an 8-lane unpacked interface array between N_REQ requesters.
- Lane groups: LO = lanes 3:0, HI = lanes 7:4.
- Produces the per-group override enables and the override mode/value consumed by the forcing module.
- Guarantees at most one owner at a time and a one-cycle release gap between successive owners.

Parameters:
N_REQ, 4, number of requesters (2..8)
MAX_HOLD, 16, maximum cycles one owner may hold the override before forced release (>=2)

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_req  input  N_REQ  per-requester request, level-sensitive
i_grp  input  2*N_REQ  per-requester group mask {HI,LO}, requester k at bits [2k+1:2k]
i_mode_z  input  N_REQ  per-requester mode: 1 = force high-impedance, 0 = force value
i_val  input  N_REQ  per-requester value bit, broadcast to all lanes of granted groups
o_gnt  output  N_REQ  one-hot grant, all-zero when no owner
o_en_lo  output  1  override enable for lanes 3:0
o_en_hi  output  1  override enable for lanes 7:4
o_mode_z  output  1  latched mode of current owner
o_val  output  1  latched value of current owner
o_timeout  output  1  single-cycle pulse when an owner is forcibly released

Behaviour:
- Interface: one clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: o_gnt=0, o_en_lo=0, o_en_hi=0, o_mode_z=0, o_val=0, o_timeout=0.
- Reset state: FSM=IDLE, hold counter=0, RR pointer=N_REQ-1, so requester 0 has first priority after reset.
- Reset asserted mid-ownership clears every output asynchronously. No DRAIN cycle is inserted.
- Eligible requester: i_req[k]=1 and i_grp[k]!=0. Requests with an all-zero group mask are ignored.
- FSM states: IDLE, OWN, DRAIN. All outputs are registered.
- IDLE:
  - If any requester is eligible, select the first eligible index searching upward from pointer+1, wrapping modulo N_REQ.
  - Latch owner index, grp, mode_z and val. Clear the counter. Go to OWN.
  - Latency: eligible in cycle t gives o_gnt and enables asserted in cycle t+1.
- OWN:
  - o_gnt[owner]=1; o_en_lo=grp[0]; o_en_hi=grp[1]; o_mode_z and o_val hold latched values.
  - Later changes to the owner's i_grp, i_mode_z and i_val are ignored.
  - Counter increments every OWN cycle.
  - Owner deasserts i_req: go to DRAIN.
  - Counter reaches MAX_HOLD-1 while i_req still high: go to DRAIN and pulse o_timeout in the first DRAIN cycle.
  - If both conditions occur in the same cycle, treat it as a normal release: no o_timeout.
  - Ownership therefore lasts at most MAX_HOLD cycles.
- DRAIN:
  - Exactly one cycle. o_gnt=0 and both enables are 0, so the forcing module releases before any new force.
  - Pointer is updated to the owner index. Go to IDLE.
- Fairness:
  - The previous owner has lowest priority in the next arbitration.
  - A timed-out owner that keeps i_req high re-competes normally.
  - Minimum spacing between two grants is one DRAIN cycle plus one IDLE cycle.
- Non-owner request changes during OWN or DRAIN have no effect until IDLE.
- o_en_lo and o_en_hi are never 1 while o_gnt is 0.

Test Plan:
- Reset, then i_req=0001, i_grp[0]=01, i_mode_z[0]=1 at cycle t -> at t+1 o_gnt=0001, o_en_lo=1, o_en_hi=0, o_mode_z=1. Drop i_req -> one DRAIN cycle with all outputs 0, then IDLE.
- All four requesting with grp=11, each dropping i_req 3 cycles after its grant -> grants in order 0,1,2,3,0. Each grant is preceded by a cycle with o_gnt=0.
- Requester 2 holds i_req=1 indefinitely, MAX_HOLD=16 -> o_gnt[2] high exactly 16 cycles, then o_timeout=1 for one cycle with enables 0. Requester 2 is re-granted if it is the only requester.
- Owner changes i_val from 0 to 1 during OWN -> o_val stays 0 until the next grant. A requester with i_grp=00 and i_req=1 is never granted.
- Assert i_rst_n=0 mid-OWN, between clock edges -> all outputs 0 immediately. After release, requester 0 wins a simultaneous 0/3 request.
- Owner drops i_req in the same cycle the counter hits MAX_HOLD-1 -> DRAIN entered, o_timeout stays 0.
